// File: rtl/bmp_pkg.sv
// Shared BMP constants, writer state encoding and the 54-byte header table
// for the 24-bpp stream writer and its testbench.
package bmp_pkg;

  localparam int BMP_HEADER_SIZE = 54;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIXEL,
    PAD,
    DONE
  } bmp_wr_state_t;

  // Header laid out as two magic bytes followed by thirteen little-endian 32-bit words;
  // planes/bpp share one word as two 16-bit halves.
  function automatic logic [7:0] bmp_header_byte(input int idx, input int width, input int height);
    int          row_bytes;
    int          pad_bytes;
    int          img_bytes;
    int          field;
    int          lane;
    logic [31:0] word;
    logic [7:0]  result;
    row_bytes = width * BYTES_PER_PIXEL;
    pad_bytes = (4 - row_bytes % 4) % 4;
    img_bytes = height * (row_bytes + pad_bytes);
    field     = (idx - 2) / 4;
    lane      = (idx - 2) % 4;
    case (field)
      0:       word = 32'(BMP_HEADER_SIZE + img_bytes);
      2:       word = 32'(BMP_HEADER_SIZE);
      3:       word = 32'd40;
      4:       word = 32'(width);
      5:       word = 32'(height);
      6:       word = {16'd24, 16'd1};
      8:       word = 32'(img_bytes);
      default: word = 32'd0;
    endcase
    if (idx == 0)      result = 8'h42;
    else if (idx == 1) result = 8'h4D;
    else               result = word[lane*8 +: 8];
    return result;
  endfunction

endpackage

// File: rtl/bmp_header_gen.sv
// Combinational header ROM: returns header byte idx for a WIDTH x HEIGHT 24-bpp image.
module bmp_header_gen
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 576
) (
  input  logic [5:0] idx,
  output logic [7:0] hdr_byte
);

  assign hdr_byte = bmp_header_byte(int'(idx), WIDTH, HEIGHT);

endmodule

// File: rtl/bmp_stream_writer.sv
// Drains 24-bit pixels from a FWFT FIFO and emits a complete 24-bpp BMP byte
// stream (header, pixel bytes, row padding) on a registered valid/ready port.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        in_re,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int ROW_BYTES = WIDTH * BYTES_PER_PIXEL;
  localparam int PAD_BYTES = (4 - ROW_BYTES % 4) % 4;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [1:0]       LAST_PAD = 2'(PAD_BYTES - 1);
  localparam logic [5:0]       LAST_HDR = 6'(BMP_HEADER_SIZE - 1);

  bmp_wr_state_t    state_q, state_d;
  logic [5:0]       hdr_idx_q, hdr_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       pad_q, pad_d;
  logic [15:0]      hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       accept;
  logic       fetch;
  logic       end_row;
  logic [5:0] hdr_gen_idx;
  logic [7:0] hdr_byte;

  // The ROM looks one entry ahead so the next header byte is ready on accept.
  assign hdr_gen_idx = (state_q == HEADER) ? hdr_idx_q + 6'd1 : 6'd0;

  bmp_header_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hdr (
    .idx      (hdr_gen_idx),
    .hdr_byte (hdr_byte)
  );

  assign accept = out_valid_q && out_ready;

  // fetch marks "the next byte to present is the first byte of a new pixel";
  // it is raised in the same cycle the preceding byte is accepted so no bubble appears.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    byte_idx_d  = byte_idx_q;
    col_d       = col_q;
    row_d       = row_q;
    pad_d       = pad_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fetch       = 1'b0;
    end_row     = 1'b0;
    in_re       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = HEADER;
          hdr_idx_d   = 6'd0;
          out_valid_d = 1'b1;
          out_data_d  = hdr_byte;
          busy_d      = 1'b1;
        end
      end
      HEADER: begin
        if (accept) begin
          if (hdr_idx_q == LAST_HDR) begin
            state_d   = PIXEL;
            hdr_idx_d = 6'd0;
            fetch     = 1'b1;
          end else begin
            hdr_idx_d  = hdr_idx_q + 6'd1;
            out_data_d = hdr_byte;
          end
        end
      end
      PIXEL: begin
        if (!out_valid_q) begin
          fetch = 1'b1;
        end else if (accept) begin
          case (byte_idx_q)
            2'd0: begin
              byte_idx_d = 2'd1;
              out_data_d = hold_q[15:8];
            end
            2'd1: begin
              byte_idx_d = 2'd2;
              out_data_d = hold_q[7:0];
            end
            default: begin
              byte_idx_d = 2'd0;
              if (col_q != LAST_COL) begin
                col_d = col_q + COL_W'(1);
                fetch = 1'b1;
              end else begin
                col_d = '0;
                if (PAD_BYTES > 0) begin
                  state_d    = PAD;
                  pad_d      = 2'd0;
                  out_data_d = 8'h00;
                end else begin
                  end_row = 1'b1;
                end
              end
            end
          endcase
        end
      end
      PAD: begin
        if (accept) begin
          if (pad_q != LAST_PAD) begin
            pad_d = pad_q + 2'd1;
          end else begin
            pad_d   = 2'd0;
            end_row = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (end_row) begin
      if (row_q == LAST_ROW) begin
        state_d     = DONE;
        row_d       = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end else begin
        state_d = PIXEL;
        row_d   = row_q + ROW_W'(1);
        fetch   = 1'b1;
      end
    end

    // An empty FIFO leaves the output slot empty; PIXEL retries every cycle.
    if (fetch) begin
      if (!in_empty) begin
        in_re       = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = in_dout[23:16];
        hold_d      = in_dout[15:0];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hdr_idx_q   <= 6'd0;
      byte_idx_q  <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      pad_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      byte_idx_q  <= byte_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pad_q       <= pad_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    hold_q <= hold_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: three image geometries driven from a FIFO model,
// every accepted byte compared against a BMP stream built from the pixel list.
module tb_bmp_stream_writer;
  import bmp_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic        start_s [3];
  logic        empty_s [3];
  logic        ready_s [3];
  logic [23:0] dout_s  [3];
  logic        re_s    [3];
  logic        valid_s [3];
  logic [7:0]  data_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];

  bmp_stream_writer #(.WIDTH(768), .HEIGHT(576)) u_big (
    .clock(clock), .reset(rst_n), .start(start_s[0]), .in_empty(empty_s[0]), .in_dout(dout_s[0]),
    .in_re(re_s[0]), .out_valid(valid_s[0]), .out_data(data_s[0]), .out_ready(ready_s[0]),
    .busy(busy_s[0]), .done(done_s[0]));

  bmp_stream_writer #(.WIDTH(4), .HEIGHT(2)) u_a (
    .clock(clock), .reset(rst_n), .start(start_s[1]), .in_empty(empty_s[1]), .in_dout(dout_s[1]),
    .in_re(re_s[1]), .out_valid(valid_s[1]), .out_data(data_s[1]), .out_ready(ready_s[1]),
    .busy(busy_s[1]), .done(done_s[1]));

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2)) u_b (
    .clock(clock), .reset(rst_n), .start(start_s[2]), .in_empty(empty_s[2]), .in_dout(dout_s[2]),
    .in_re(re_s[2]), .out_valid(valid_s[2]), .out_data(data_s[2]), .out_ready(ready_s[2]),
    .busy(busy_s[2]), .done(done_s[2]));

  int vectors;
  int miscompares;
  int re_cnt;
  int first_valid;
  int done_cyc;
  int last_acc_g;

  logic [23:0] fifo_q [$];
  logic [23:0] pix_q  [$];
  logic [7:0]  exp_q  [$];
  logic [7:0]  got_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put_le(input logic [31:0] v, input int nb);
    for (int k = 0; k < nb; k++) exp_q.push_back(v[k*8 +: 8]);
  endtask

  // Expected file image for as many pixels as pix_q holds.
  task automatic build_exp(input int w, input int h);
    int img;
    int rowlen;
    logic [23:0] p;
    img = h * (((w * 3) + 3) / 4 * 4);
    exp_q.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    put_le(54 + img, 4); put_le(0, 4); put_le(54, 4); put_le(40, 4);
    put_le(w, 4); put_le(h, 4); put_le(1, 2); put_le(24, 2);
    put_le(0, 4); put_le(img, 4);
    for (int k = 0; k < 4; k++) put_le(0, 4);
    for (int r = 0; r < h; r++) begin
      rowlen = 0;
      for (int c = 0; c < w; c++) begin
        if (r * w + c >= pix_q.size()) return;
        p = pix_q[r * w + c];
        exp_q.push_back(p[23:16]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        rowlen += 3;
      end
      while (rowlen % 4 != 0) begin
        exp_q.push_back(8'h00);
        rowlen++;
      end
    end
  endtask

  task automatic load_pix(input int n, input bit rnd);
    logic [23:0] p;
    pix_q.delete();
    fifo_q.delete();
    for (int k = 0; k < n; k++) begin
      p = rnd ? 24'($urandom()) : 24'(k + 1);
      pix_q.push_back(p);
      fifo_q.push_back(p);
    end
  endtask

  // Cycle 0 is the start cycle. Returns at the top of a cycle once stop_at bytes were
  // accepted (stop_at >= 0), or two cycles after the final accept.
  task automatic run_image(input int i, input int total, input bit rnd, input int stall_at,
                           input int stop_at, input int busy_pulse);
    int c, n, stall_cnt, last_acc;
    bit pop, stalled, prev_hold;
    logic [7:0]  prev_data;
    logic [23:0] tmp;
    c = 0; n = 0; stall_cnt = 0; last_acc = -10;
    pop = 0; stalled = 0; prev_hold = 0; prev_data = 8'h00;
    got_q.delete();
    re_cnt = 0; first_valid = -1; done_cyc = -1;
    forever begin
      if (pop) begin
        tmp = fifo_q.pop_front();
        pop = 0;
      end
      if (stop_at >= 0 && n >= stop_at) break;
      if (c > 20000) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout: dut %0d accepted %0d of %0d bytes", i, n, total);
        break;
      end
      if (stall_at >= 0 && !stalled && n >= stall_at) begin
        stall_cnt = 10;
        stalled = 1;
      end
      start_s[i] = (c == 0) || (c == busy_pulse);
      ready_s[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      empty_s[i] = (fifo_q.size() == 0) || (stall_cnt > 0);
      dout_s[i]  = (fifo_q.size() != 0) ? fifo_q[0] : 24'h0;
      if (stall_cnt > 0) stall_cnt--;
      #1;
      if (c > 0) chk("busy", busy_s[i], n < total);
      else       chk("busy_at_start", busy_s[i], 0);
      chk("done", done_s[i], (n == total) && (c == last_acc + 1));
      if (done_s[i]) done_cyc = c;
      if (prev_hold) begin
        chk("stall_valid", valid_s[i], 1);
        chk("stall_data", data_s[i], prev_data);
      end
      if (re_s[i]) begin
        chk("pop_when_empty", empty_s[i], 0);
        re_cnt++;
        pop = 1;
      end
      if (valid_s[i] && first_valid < 0) first_valid = c;
      if (valid_s[i] && ready_s[i]) begin
        if (n < exp_q.size()) chk($sformatf("byte%0d", n), data_s[i], exp_q[n]);
        got_q.push_back(data_s[i]);
        n++;
        last_acc = c;
      end
      prev_hold = valid_s[i] && !ready_s[i];
      prev_data = data_s[i];
      @(posedge clock);
      #1;
      c++;
      if (n >= total && c > last_acc + 1) break;
    end
    last_acc_g = last_acc;
    start_s[i] = 1'b0;
    ready_s[i] = 1'b0;
    empty_s[i] = 1'b1;
  endtask

  logic [7:0]  lit_hdr [0:5];
  logic [7:0]  lit_dim [0:7];
  logic [23:0] px;

  initial begin
    vectors = 0;
    miscompares = 0;
    lit_hdr = '{8'h42, 8'h4D, 8'h36, 8'h40, 8'h14, 8'h00};
    lit_dim = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h40, 8'h02, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      empty_s[k] = 1'b0;
      ready_s[k] = 1'b1;
      dout_s[k]  = 24'h123456;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", valid_s[k], 0);
      chk("rst_data", data_s[k], 0);
      chk("rst_busy", busy_s[k], 0);
      chk("rst_done", done_s[k], 0);
      chk("rst_in_re", re_s[k], 0);
    end
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("idle_in_re", re_s[k], 0);
      chk("idle_valid", valid_s[k], 0);
      empty_s[k] = 1'b1;
    end

    // 4x2, no padding, counting pixels, full throughput
    load_pix(8, 0);
    build_exp(4, 2);
    chk("a_model_len", exp_q.size(), 78);
    chk("a_model_fsize", exp_q[2], 8'h4E);
    run_image(1, 78, 0, -1, -1, -1);
    chk("a_bytes", got_q.size(), 78);
    chk("a_byte54", got_q[54], 8'h00);
    chk("a_byte56", got_q[56], 8'h01);
    chk("a_first_valid", first_valid, 1);
    chk("a_span", last_acc_g - first_valid + 1, 78);
    chk("a_done_cycle", done_cyc, 79);
    chk("a_pops", re_cnt, 8);

    // 3x2, three pad bytes per row
    load_pix(6, 1);
    build_exp(3, 2);
    chk("b_model_len", exp_q.size(), 78);
    run_image(2, 78, 0, -1, -1, -1);
    chk("b_bytes", got_q.size(), 78);
    chk("b_pad63", got_q[63], 8'h00);
    chk("b_pad64", got_q[64], 8'h00);
    chk("b_pad65", got_q[65], 8'h00);
    px = pix_q[3];
    chk("b_row1_start", got_q[66], px[23:16]);
    chk("b_pops", re_cnt, 6);
    chk("b_done_cycle", done_cyc, 79);

    // random backpressure with a 10-cycle FIFO drought mid-row
    load_pix(8, 1);
    build_exp(4, 2);
    run_image(1, 78, 1, 60, -1, -1);
    chk("a_bp_bytes", got_q.size(), 78);
    chk("a_bp_pops", re_cnt, 8);
    chk("a_bp_fifo_drained", fifo_q.size(), 0);
    load_pix(6, 1);
    build_exp(3, 2);
    run_image(2, 78, 1, 68, -1, -1);
    chk("b_bp_bytes", got_q.size(), 78);
    chk("b_bp_pops", re_cnt, 6);

    // 768x576 header, then reset at byte 200
    load_pix(60, 1);
    build_exp(768, 576);
    chk("big_model_len", exp_q.size(), 234);
    run_image(0, 1327158, 0, -1, 200, -1);
    for (int k = 0; k < 6; k++) chk($sformatf("big_hdr%0d", k), got_q[k], lit_hdr[k]);
    for (int k = 0; k < 8; k++) chk($sformatf("big_hdr%0d", 18 + k), got_q[18 + k], lit_dim[k]);
    chk("big_hdr10", got_q[10], 8'h36);
    chk("big_pops", re_cnt, 49);
    empty_s[0] = 1'b0;
    dout_s[0]  = 24'hABCDEF;
    ready_s[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid_s[0], 0);
    chk("mid_rst_data", data_s[0], 0);
    chk("mid_rst_busy", busy_s[0], 0);
    chk("mid_rst_done", done_s[0], 0);
    chk("mid_rst_in_re", re_s[0], 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("rst_low_in_re", re_s[0], 0);
    end
    rst_n = 1'b1;
    empty_s[0] = 1'b1;

    // fresh image after reset; a start at cycle 15 must not disturb it
    load_pix(60, 1);
    build_exp(768, 576);
    run_image(0, 1327158, 0, -1, 40, 15);
    chk("restart_byte0", got_q[0], 8'h42);
    chk("restart_byte1", got_q[1], 8'h4D);
    chk("restart_bytes", got_q.size(), 40);
    chk("restart_busy", busy_s[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
